bomb_ctrl: RTL
==============

BOMB_CTRL -- requirements
Module: bomb_ctrl

Interface
REQ-001 SHALL provide parameter CLK_HZ, default 1000, Clk cycles per game second.
REQ-002 SHALL provide parameter TIME_SEC, default 300, countdown start value in seconds (1..1023).
REQ-003 SHALL provide parameter BEEP_CYC, default 100, beep pulse length in Clk cycles (< CLK_HZ/2).
REQ-004 Clk  in  1  system clock (1 kHz nominal); one clock; all logic on posedge Clk.
REQ-005 Rst_n  in  1  reset, synchronous, active-low.
REQ-006 start_btn  in  1  debounced level; rising edge arms the game.
REQ-007 wrong  in  1  toggle from the puzzle module; any level change = one strike.
REQ-008 corrtip  in  1  toggle from the puzzle module; any level change = one stage cleared.
REQ-009 done  in  1  level; high = puzzle solved.
REQ-010 oseed  out  12  puzzle seed, six 2-bit color indices, MSB pair first.
REQ-011 mod  out  1  rule-table select for the puzzle module.
REQ-012 wrong_time  out  2  strike count 0..2 fed back to the puzzle module.
REQ-013 time_left  out  10  remaining seconds, binary.
REQ-014 beep  out  1  buzzer enable.
REQ-015 defused  out  1  level, game won.
REQ-016 exploded  out  1  level, game lost.

Function
REQ-017 SHALL implement states IDLE, ARM, RUN, DEFUSED, EXPLODED; IDLE->ARM on start_btn rising edge; ARM->RUN after exactly 1 cycle; DEFUSED/EXPLODED->IDLE on start_btn rising edge.
REQ-018 SHALL run a free-running 12-bit Fibonacci LFSR, polynomial x^12+x^6+x^4+x+1, advancing every cycle in every state, reset value 12'hACE, never all-zero.
REQ-019 In ARM: oseed <= LFSR value; mod <= LFSR bit 0; wrong_time <= 0; time_left <= TIME_SEC; prescaler cleared; defused/exploded <= 0.
REQ-020 oseed and mod SHALL hold constant outside ARM.
REQ-021 SHALL detect input toggles by comparing wrong/corrtip with 1-cycle-delayed copies; delayed copies update every cycle in all states; toggles outside RUN ignored.
REQ-022 In RUN, a wrong toggle with wrong_time<2 SHALL increment wrong_time next cycle; with wrong_time==2 SHALL go to EXPLODED, wrong_time stays 2.
REQ-023 Prescaler SHALL count 0..P-1 in RUN, P = CLK_HZ - wrong_time*(CLK_HZ/4); on wrap, time_left decrements by 1.
REQ-024 Decrement reaching 0 SHALL go to EXPLODED the same cycle time_left becomes 0; time_left never wraps below 0.
REQ-025 In RUN, done high SHALL go to DEFUSED next cycle.
REQ-026 Same-cycle priority in RUN: done > third strike > timeout; lower events discarded.
REQ-027 time_left and wrong_time SHALL freeze in DEFUSED/EXPLODED.
REQ-028 beep SHALL be high for BEEP_CYC cycles starting at each second wrap in RUN, and for BEEP_CYC cycles after each corrtip toggle in RUN (retrigger restarts count).
REQ-029 beep SHALL be held high continuously in EXPLODED, low in IDLE, ARM, DEFUSED.
REQ-030 defused high only in DEFUSED; exploded high only in EXPLODED.

Reset
REQ-031 Rst_n low at a posedge Clk SHALL force, next cycle: state IDLE, LFSR 12'hACE, oseed 0, mod 0, wrong_time 0, time_left TIME_SEC, prescaler 0, beep 0, defused 0, exploded 0, toggle history <= current input levels.
REQ-032 Reset mid-RUN SHALL abort the game with no strike, defuse or explode recorded.

Verification (CLK_HZ=8, TIME_SEC=3, BEEP_CYC=2)
REQ-033 Reset, start pulse -> ARM 1 cycle, oseed equals LFSR value at ARM, time_left=3, then RUN; no inputs -> time_left 2,1,0 at 8-cycle intervals, exploded=1 at the 24th RUN cycle, beep stuck high.
REQ-034 RUN, toggle wrong once -> wrong_time=1, next second lasts 6 cycles; toggle twice more -> EXPLODED, wrong_time=2.
REQ-035 RUN, raise done at cycle 5 -> defused=1 at cycle 6, time_left frozen at 3, beep 0.
REQ-036 Same cycle: done high and third wrong toggle -> DEFUSED, exploded stays 0.
REQ-037 corrtip toggle in RUN -> beep high exactly 2 cycles; toggles in IDLE -> no beep, no strike.
REQ-038 Rst_n low during RUN with wrong_time=2 -> IDLE, wrong_time=0, time_left=3, outputs at reset values.

Source files
------------

// File: rtl/bomb_ctrl.sv
// -----------------------------------------------------------------------------
// bomb_ctrl -- game controller for a "defuse the bomb" puzzle.
//
// Arms on a start_btn rising edge, hands the puzzle module a fresh seed and
// rule-table select, then counts down from TIME_SEC seconds.  Each strike
// shortens every following second by a quarter.  The puzzle reports a solve
// (done), which defuses the bomb.  A third strike or reaching zero explodes it.
//
// Parameters:
//   CLK_HZ    clock cycles per game second
//   TIME_SEC  countdown start value in seconds (1..1023)
//   BEEP_CYC  beep pulse length in clock cycles (< CLK_HZ/2)
//
// Ports:
//   Clk         in   system clock, all logic on its rising edge
//   Rst_n       in   synchronous active-low reset
//   start_btn   in   debounced level, rising edge arms / returns to idle
//   wrong       in   toggle from the puzzle, each level change is one strike
//   corrtip     in   toggle from the puzzle, each level change is one stage cleared
//   done        in   level, high when the puzzle is solved
//   oseed       out  puzzle seed, six 2-bit color indices, MSB pair first
//   mod         out  rule-table select for the puzzle
//   wrong_time  out  strike count 0..2
//   time_left   out  remaining seconds
//   beep        out  buzzer enable
//   defused     out  game won
//   exploded    out  game lost
// -----------------------------------------------------------------------------
module bomb_ctrl #(
    parameter int CLK_HZ   = 1000,
    parameter int TIME_SEC = 300,
    parameter int BEEP_CYC = 100
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        start_btn,
    input  logic        wrong,
    input  logic        corrtip,
    input  logic        done,
    output logic [11:0] oseed,
    output logic        mod,
    output logic [1:0]  wrong_time,
    output logic [9:0]  time_left,
    output logic        beep,
    output logic        defused,
    output logic        exploded
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BW = (BEEP_CYC > 0) ? $clog2(BEEP_CYC + 1) : 1;

    // Last prescaler value of a second for 0, 1 and 2 strikes.
    localparam logic [PW-1:0] LAST_0 = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] LAST_1 = PW'(CLK_HZ - CLK_HZ / 4 - 1);
    localparam logic [PW-1:0] LAST_2 = PW'(CLK_HZ - 2 * (CLK_HZ / 4) - 1);

    localparam logic [BW-1:0]  BEEP_LOAD = BW'(BEEP_CYC);
    localparam logic [9:0]     TIME_INIT = 10'(TIME_SEC);
    localparam logic [11:0]    LFSR_INIT = 12'hACE;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARM      = 3'd1;
    localparam logic [2:0] S_RUN      = 3'd2;
    localparam logic [2:0] S_DEFUSED  = 3'd3;
    localparam logic [2:0] S_EXPLODED = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [11:0]   lfsr_q, lfsr_d;
    logic [11:0]   seed_q, seed_d;
    logic          mod_q, mod_d;
    logic [1:0]    wt_q, wt_d;
    logic [9:0]    tl_q, tl_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] beep_cnt_q, beep_cnt_d;

    // One-cycle-delayed input copies for edge / toggle detection.
    logic start_q, wrong_q, corr_q;

    logic          start_rise, wrong_tog, corr_tog;
    logic [PW-1:0] last_tick;
    logic          sec_wrap;

    assign start_rise = start_btn & ~start_q;
    assign wrong_tog  = wrong ^ wrong_q;
    assign corr_tog   = corrtip ^ corr_q;

    // x^12 + x^6 + x^4 + x + 1, shifting toward the MSB.
    assign lfsr_d = {lfsr_q[10:0], lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0]};

    always_comb begin
        case (wt_q)
            2'd0:    last_tick = LAST_0;
            2'd1:    last_tick = LAST_1;
            default: last_tick = LAST_2;
        endcase
    end

    // ">=" rather than "==": a strike can shorten the second while the
    // prescaler is already past the new end point.
    assign sec_wrap = (presc_q >= last_tick);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        seed_d     = seed_q;
        mod_d      = mod_q;
        wt_d       = wt_q;
        tl_d       = tl_q;
        presc_d    = presc_q;
        beep_cnt_d = '0;

        case (state_q)
            S_IDLE: begin
                if (start_rise) state_d = S_ARM;
            end
            S_ARM: begin
                seed_d  = lfsr_q;
                mod_d   = lfsr_q[0];
                wt_d    = 2'd0;
                tl_d    = TIME_INIT;
                presc_d = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                beep_cnt_d = (beep_cnt_q != '0) ? beep_cnt_q - 1'b1 : '0;
                if (corr_tog) beep_cnt_d = BEEP_LOAD;

                // Priority: solve, then third strike, then timeout.
                if (done) begin
                    state_d = S_DEFUSED;
                end else if (wrong_tog && wt_q == 2'd2) begin
                    state_d = S_EXPLODED;
                end else begin
                    if (wrong_tog) wt_d = wt_q + 2'd1;
                    if (sec_wrap) begin
                        presc_d    = '0;
                        beep_cnt_d = BEEP_LOAD;
                        if (tl_q != '0) tl_d = tl_q - 10'd1;
                        if (tl_q <= 10'd1) state_d = S_EXPLODED;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            S_DEFUSED, S_EXPLODED: begin
                if (start_rise) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!Rst_n) begin
            state_q    <= S_IDLE;
            lfsr_q     <= LFSR_INIT;
            seed_q     <= '0;
            mod_q      <= 1'b0;
            wt_q       <= 2'd0;
            tl_q       <= TIME_INIT;
            presc_q    <= '0;
            beep_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            seed_q     <= seed_d;
            mod_q      <= mod_d;
            wt_q       <= wt_d;
            tl_q       <= tl_d;
            presc_q    <= presc_d;
            beep_cnt_q <= beep_cnt_d;
        end
    end

    // NOTE: the history flops load the live input levels with or without
    // reset, so no reset branch is needed and no false edge follows reset.
    always_ff @(posedge Clk) begin
        start_q <= start_btn;
        wrong_q <= wrong;
        corr_q  <= corrtip;
    end

    assign oseed      = seed_q;
    assign mod        = mod_q;
    assign wrong_time = wt_q;
    assign time_left  = tl_q;
    assign beep       = (state_q == S_EXPLODED) | ((state_q == S_RUN) & (beep_cnt_q != '0));
    assign defused    = (state_q == S_DEFUSED);
    assign exploded   = (state_q == S_EXPLODED);

endmodule
